// File: rtl/mips_data_memory_if.sv
// Core-side data bus of the single-cycle MIPS data memory: address, write strobe/data, read data.
interface mips_data_memory_if;
  logic [31:0] a;
  logic        we;
  logic [31:0] wd;
  logic [31:0] rd;

  modport master (output a, we, wd, input rd);
  modport slave  (input a, we, wd, output rd);
endinterface

// File: rtl/mips_data_memory.sv
// Data-side responder for the MIPS core: word RAM with combinational read plus an MMIO
// window holding a cycle counter, a down-counting timer with interrupt, and an 8-bit GPIO.
module mips_data_memory #(
  parameter int unsigned ADDR_WIDTH = 10,
  parameter logic [15:0] MMIO_BASE  = 16'hFFFF
) (
  input  logic                clk,
  input  logic                rst_n,
  mips_data_memory_if.slave   bus,
  output logic                irq,
  output logic [7:0]          gpio_out
);

  localparam int unsigned DEPTH = 1 << ADDR_WIDTH;

  typedef enum logic [13:0] {
    OFF_CYCLE  = 14'd0,
    OFF_TIMER  = 14'd1,
    OFF_CTRL   = 14'd2,
    OFF_STATUS = 14'd3,
    OFF_RELOAD = 14'd4,
    OFF_GPIO   = 14'd5
  } mmio_off_e;

  logic [31:0] r_mem [DEPTH];

  logic [31:0] r_cycle;
  logic [31:0] r_timer;
  logic [2:0]  r_ctrl;
  logic        r_expired;
  logic [31:0] r_reload;
  logic [7:0]  r_gpio;
  logic        r_irq;

  logic                  w_is_mmio;
  logic [ADDR_WIDTH-1:0] w_idx;
  logic [13:0]           w_off;
  logic                  w_mmio_we;
  logic                  w_ram_we;
  logic                  w_wr_timer;
  logic                  w_wr_ctrl;
  logic                  w_wr_status;
  logic                  w_wr_reload;
  logic                  w_wr_gpio;
  logic [31:0]           w_timer_next;
  logic                  w_expire;
  logic [2:0]            w_ctrl_next;
  logic                  w_expired_next;
  logic [31:0]           w_rd;
  logic                  w_unused;

  assign w_is_mmio = (bus.a[31:16] == MMIO_BASE);
  assign w_idx     = bus.a[ADDR_WIDTH+1:2];
  assign w_off     = bus.a[15:2];
  assign w_mmio_we = bus.we & w_is_mmio;
  assign w_ram_we  = bus.we & ~w_is_mmio & rst_n;
  assign w_unused  = ^bus.a[1:0];

  assign w_wr_timer  = w_mmio_we && (w_off == OFF_TIMER);
  assign w_wr_ctrl   = w_mmio_we && (w_off == OFF_CTRL);
  assign w_wr_status = w_mmio_we && (w_off == OFF_STATUS);
  assign w_wr_reload = w_mmio_we && (w_off == OFF_RELOAD);
  assign w_wr_gpio   = w_mmio_we && (w_off == OFF_GPIO);

  always_ff @(posedge clk) begin
    if (w_ram_we) r_mem[w_idx] <= bus.wd;
  end

  // A CPU write to TIMER pre-empts both decrement and reload, so no expiry on that edge.
  always_comb begin
    w_timer_next = r_timer;
    w_expire     = 1'b0;
    if (w_wr_timer) begin
      w_timer_next = bus.wd;
    end else if (r_ctrl[0] && (r_timer == 32'd1)) begin
      w_timer_next = r_ctrl[1] ? r_reload : '0;
      w_expire     = 1'b1;
    end else if (r_ctrl[0] && (r_timer > 32'd1)) begin
      w_timer_next = r_timer - 32'd1;
    end
    w_ctrl_next    = w_wr_ctrl ? bus.wd[2:0] : r_ctrl;
    w_expired_next = w_expire | (r_expired & ~(w_wr_status & bus.wd[0]));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cycle   <= '0;
      r_timer   <= '0;
      r_ctrl    <= '0;
      r_expired <= 1'b0;
      r_reload  <= '0;
      r_gpio    <= '0;
      r_irq     <= 1'b0;
    end else begin
      r_cycle   <= r_cycle + 32'd1;
      r_timer   <= w_timer_next;
      r_ctrl    <= w_ctrl_next;
      r_expired <= w_expired_next;
      r_irq     <= w_expired_next & w_ctrl_next[2];
      if (w_wr_reload) r_reload <= bus.wd;
      if (w_wr_gpio)   r_gpio   <= bus.wd[7:0];
    end
  end

  always_comb begin
    w_rd = '0;
    if (w_is_mmio) begin
      case (w_off)
        OFF_CYCLE:  w_rd = r_cycle;
        OFF_TIMER:  w_rd = r_timer;
        OFF_CTRL:   w_rd = {29'd0, r_ctrl};
        OFF_STATUS: w_rd = {31'd0, r_expired};
        OFF_RELOAD: w_rd = r_reload;
        OFF_GPIO:   w_rd = {24'd0, r_gpio};
        default:    w_rd = '0;
      endcase
    end else begin
      w_rd = r_mem[w_idx];
    end
  end

  assign bus.rd   = w_rd;
  assign irq      = r_irq;
  assign gpio_out = r_gpio;

endmodule
